// File: rtl/score_display_ctrl_if.sv
// Bus between the score display controller and its neighbours: score
// commands from game logic, beam position from the VGA controller, the
// shared digit-sprite ROM, and pixel/score results toward the colour mapper.
interface score_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      score_inc;
    logic                      score_clr;
    logic [9:0]                DrawX;
    logic [9:0]                DrawY;
    logic                      blank;
    logic [11:0]               rom_address;
    logic [3:0]                rom_q;
    logic                      pix_on;
    logic [3:0]                pix_index;
    logic [4*NUM_DIGITS-1:0]   score_bcd;
    logic                      overflow;

    modport master (
        output score_inc, score_clr, DrawX, DrawY, blank, rom_q,
        input  rom_address, pix_on, pix_index, score_bcd, overflow
    );

    modport slave (
        input  score_inc, score_clr, DrawX, DrawY, blank, rom_q,
        output rom_address, pix_on, pix_index, score_bcd, overflow
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Score display controller: BCD score counter with sticky overflow, a
// display copy refreshed only at vblank start (no mid-frame tearing), and
// address sequencing of one shared 16x16 digit-sprite ROM across all digit
// positions. Pixel output is registered one posedge after the address.
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, leading zero
// digits are not drawn (the least-significant digit is always drawn).
module score_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int ORIGIN_X    = 16,
    parameter int ORIGIN_Y    = 16,
    parameter int DIGIT_PITCH = 16
) (
    input  logic vga_clk,
    input  logic reset,
    score_display_if.slave bus
);
    localparam int W = 4 * NUM_DIGITS;

    // Region bounds at 11 bits so a beam left of/above the origin never
    // aliases into the digit row after subtraction.
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + NUM_DIGITS * DIGIT_PITCH);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + 16);

    logic [W-1:0]  score_q, score_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  disp_q, disp_d;
    logic          pix_on_q, pix_on_d;
    logic [3:0]    pix_index_q, pix_index_d;

    logic [W-1:0]  inc_val;
    logic          inc_wrap;
    logic          vblank_start;

    logic [10:0]   x_ext, y_ext, dx;
    logic          band;
    logic          in_region;
    logic          suppress;
    logic [3:0]    digit, row, col, d_k;
`ifdef LEADING_ZERO_BLANK_EN
    logic          lead_zero, lz_k;
`endif

    // BCD +1 with ripple carry; carry out of the MSD means all-9s wrapped.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        inc_val = score_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (score_q[i*4 +: 4] == 4'd9) begin
                    inc_val[i*4 +: 4] = 4'd0;
                end else begin
                    inc_val[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        inc_wrap = carry;
    end

    // Score next-state: clear wins over increment; overflow is sticky.
    always_comb begin
        score_d    = score_q;
        overflow_d = overflow_q;
        if (bus.score_clr) begin
            score_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.score_inc) begin
            score_d = inc_val;
            if (inc_wrap) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Display copy takes the pre-increment score exactly at vblank start.
    always_comb begin
        vblank_start = (bus.DrawY == 10'd480) && (bus.DrawX == 10'd0);
        disp_d       = vblank_start ? score_q : disp_q;
    end

    // Region decode: find the digit window under the beam (position 0 is
    // the MSD) and form the shared ROM address from the displayed digit.
    always_comb begin
        x_ext     = {1'b0, bus.DrawX};
        y_ext     = {1'b0, bus.DrawY};
        dx        = x_ext - X_LO;
        row       = 4'(y_ext - Y_LO);
        band      = (y_ext >= Y_LO) && (y_ext < Y_HI) &&
                    (x_ext >= X_LO) && (x_ext < X_HI);
        in_region = 1'b0;
        digit     = 4'd0;
        col       = 4'd0;
        suppress  = 1'b0;
        d_k       = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = 1'b1;
        lz_k      = 1'b0;
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d_k = disp_q[(NUM_DIGITS-1-k)*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            lz_k      = lead_zero && (d_k == 4'd0) && (k != NUM_DIGITS - 1);
            lead_zero = lead_zero && (d_k == 4'd0);
`endif
            // Columns 16..PITCH-1 of each slot are the inter-digit gap.
            if (band && (dx >= 11'(k * DIGIT_PITCH)) &&
                (dx < 11'(k * DIGIT_PITCH + 16))) begin
                in_region = 1'b1;
                digit     = d_k;
                col       = 4'(dx - 11'(k * DIGIT_PITCH));
`ifdef LEADING_ZERO_BLANK_EN
                suppress  = lz_k;
`else
                suppress  = 1'b0;
`endif
            end
        end
    end

    // Pixel decision uses rom_q returned at the negedge for this cycle's address.
    always_comb begin
        pix_on_d    = in_region && bus.blank && (bus.rom_q != 4'd0) && !suppress;
        pix_index_d = pix_on_d ? bus.rom_q : 4'd0;
    end

    // State registers; reset darkens the outputs and zeroes the display copy.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            score_q     <= '0;
            overflow_q  <= 1'b0;
            disp_q      <= '0;
            pix_on_q    <= 1'b0;
            pix_index_q <= 4'd0;
        end else begin
            score_q     <= score_d;
            overflow_q  <= overflow_d;
            disp_q      <= disp_d;
            pix_on_q    <= pix_on_d;
            pix_index_q <= pix_index_d;
        end
    end

    assign bus.rom_address = in_region ? {digit, row, col} : 12'd0;
    assign bus.pix_on      = pix_on_q;
    assign bus.pix_index   = pix_index_q;
    assign bus.score_bcd   = score_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl (NUM_DIGITS=4, origin 16/16,
// DIGIT_PITCH=20 so that inter-digit gap columns exist).
module tb_score_display_ctrl;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    score_display_if #(.NUM_DIGITS(4)) bus ();

    score_display_ctrl #(
        .NUM_DIGITS(4), .ORIGIN_X(16), .ORIGIN_Y(16), .DIGIT_PITCH(20)
    ) dut (
        .vga_clk(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vblank_latch();
        bus.DrawY = 10'd480;
        bus.DrawX = 10'd0;
        tick();
        bus.DrawY = 10'd0;
        bus.DrawX = 10'd0;
    endtask

    task automatic set_score(input int n);
        bus.score_clr = 1'b1;
        tick();
        bus.score_clr = 1'b0;
        bus.score_inc = 1'b1;
        repeat (n) tick();
        bus.score_inc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if (bus.score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL reset_score: got %h expected 0000", bus.score_bcd);
        end
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow);
        end
        n_checks++;
        if (bus.pix_on !== 1'b0 || bus.pix_index !== 4'h0) begin
            n_fail++; $display("FAIL reset_pix: got %b/%h expected 0/0", bus.pix_on, bus.pix_index);
        end
        bus.DrawX = 10'd21;
        bus.DrawY = 10'd19;
        #1;
        n_checks++;
        if (bus.rom_address !== 12'h035) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 035", bus.rom_address);
        end
        rst = 1'b0;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        tick();
    endtask

    task automatic test_count();
        bus.score_inc = 1'b1;
        repeat (1234) tick();
        bus.score_inc = 1'b0;
        n_checks++;
        if (bus.score_bcd !== 16'h1234) begin
            n_fail++; $display("FAIL count_1234: got %h expected 1234", bus.score_bcd);
        end
        bus.DrawX = 10'd16; bus.DrawY = 10'd16; #1;
        n_checks++;
        if (bus.rom_address !== 12'h000) begin
            n_fail++; $display("FAIL count_prelatch_addr: got %h expected 000", bus.rom_address);
        end
        vblank_latch();
        bus.DrawX = 10'd16; bus.DrawY = 10'd16; #1;
        n_checks++;
        if (bus.rom_address !== 12'h100) begin
            n_fail++; $display("FAIL count_addr_pos0: got %h expected 100", bus.rom_address);
        end
        bus.DrawX = 10'd36; #1;
        n_checks++;
        if (bus.rom_address !== 12'h200) begin
            n_fail++; $display("FAIL count_addr_pos1: got %h expected 200", bus.rom_address);
        end
        bus.DrawX = 10'd91; bus.DrawY = 10'd31; #1;
        n_checks++;
        if (bus.rom_address !== 12'h4FF) begin
            n_fail++; $display("FAIL count_addr_pos3_corner: got %h expected 4ff", bus.rom_address);
        end
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
    endtask

    task automatic test_overflow();
        set_score(9999);
        n_checks++;
        if (bus.score_bcd !== 16'h9999 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_9999: got %h/%b expected 9999/0", bus.score_bcd, bus.overflow);
        end
        bus.score_inc = 1'b1; tick(); bus.score_inc = 1'b0;
        n_checks++;
        if (bus.score_bcd !== 16'h0000 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_wrap: got %h/%b expected 0000/1", bus.score_bcd, bus.overflow);
        end
        bus.score_inc = 1'b1; tick(); bus.score_inc = 1'b0;
        n_checks++;
        if (bus.score_bcd !== 16'h0001 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %h/%b expected 0001/1", bus.score_bcd, bus.overflow);
        end
        bus.score_inc = 1'b1; bus.score_clr = 1'b1; tick();
        bus.score_inc = 1'b0; bus.score_clr = 1'b0;
        n_checks++;
        if (bus.score_bcd !== 16'h0000 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr_priority: got %h/%b expected 0000/0", bus.score_bcd, bus.overflow);
        end
    endtask

    task automatic test_latch_same_cycle();
        set_score(5);
        bus.DrawY = 10'd480; bus.DrawX = 10'd0; bus.score_inc = 1'b1;
        tick();
        bus.score_inc = 1'b0;
        n_checks++;
        if (bus.score_bcd !== 16'h0006) begin
            n_fail++; $display("FAIL latch_inc_score: got %h expected 0006", bus.score_bcd);
        end
        bus.DrawY = 10'd16; bus.DrawX = 10'd76; #1;
        n_checks++;
        if (bus.rom_address !== 12'h500) begin
            n_fail++; $display("FAIL latch_pre_inc_value: got %h expected 500", bus.rom_address);
        end
    endtask

    task automatic test_midframe();
        bus.DrawY = 10'd100; bus.DrawX = 10'd50; bus.score_inc = 1'b1;
        tick();
        bus.score_inc = 1'b0;
        bus.DrawY = 10'd16; bus.DrawX = 10'd76; #1;
        n_checks++;
        if (bus.rom_address !== 12'h500) begin
            n_fail++; $display("FAIL midframe_no_tear: got %h expected 500", bus.rom_address);
        end
        bus.DrawY = 10'd480; bus.DrawX = 10'd1; tick();
        bus.DrawY = 10'd479; bus.DrawX = 10'd0; tick();
        bus.DrawY = 10'd16; bus.DrawX = 10'd76; #1;
        n_checks++;
        if (bus.rom_address !== 12'h500) begin
            n_fail++; $display("FAIL midframe_near_vblank: got %h expected 500", bus.rom_address);
        end
        vblank_latch();
        bus.DrawY = 10'd16; bus.DrawX = 10'd76; #1;
        n_checks++;
        if (bus.rom_address !== 12'h700) begin
            n_fail++; $display("FAIL midframe_next_frame: got %h expected 700", bus.rom_address);
        end
    endtask

    task automatic test_pixel();
        // display holds 0007
        bus.blank = 1'b1; bus.rom_q = 4'h7; bus.DrawX = 10'd76; bus.DrawY = 10'd20;
        tick();
        n_checks++;
        if (bus.pix_on !== 1'b1 || bus.pix_index !== 4'h7) begin
            n_fail++; $display("FAIL pix_opaque: got %b/%h expected 1/7", bus.pix_on, bus.pix_index);
        end
        bus.blank = 1'b0; tick();
        n_checks++;
        if (bus.pix_on !== 1'b0 || bus.pix_index !== 4'h0) begin
            n_fail++; $display("FAIL pix_blanked: got %b/%h expected 0/0", bus.pix_on, bus.pix_index);
        end
        bus.blank = 1'b1; bus.rom_q = 4'h0; tick();
        n_checks++;
        if (bus.pix_on !== 1'b0 || bus.pix_index !== 4'h0) begin
            n_fail++; $display("FAIL pix_transparent: got %b/%h expected 0/0", bus.pix_on, bus.pix_index);
        end
        bus.rom_q = 4'h7; bus.DrawX = 10'd32; bus.DrawY = 10'd16; #1;
        n_checks++;
        if (bus.rom_address !== 12'h000) begin
            n_fail++; $display("FAIL gap_addr: got %h expected 000", bus.rom_address);
        end
        tick();
        n_checks++;
        if (bus.pix_on !== 1'b0) begin
            n_fail++; $display("FAIL gap_pix: got %b expected 0", bus.pix_on);
        end
        bus.DrawX = 10'd0; #1;
        n_checks++;
        if (bus.rom_address !== 12'h000) begin
            n_fail++; $display("FAIL left_addr: got %h expected 000", bus.rom_address);
        end
        tick();
        n_checks++;
        if (bus.pix_on !== 1'b0) begin
            n_fail++; $display("FAIL left_pix: got %b expected 0", bus.pix_on);
        end
        bus.DrawX = 10'd95; tick();
        n_checks++;
        if (bus.pix_on !== 1'b0) begin
            n_fail++; $display("FAIL last_gap_pix: got %b expected 0", bus.pix_on);
        end
        bus.DrawX = 10'd96; tick();
        n_checks++;
        if (bus.pix_on !== 1'b0) begin
            n_fail++; $display("FAIL right_edge_pix: got %b expected 0", bus.pix_on);
        end
        bus.DrawX = 10'd76; bus.DrawY = 10'd15; tick();
        n_checks++;
        if (bus.pix_on !== 1'b0) begin
            n_fail++; $display("FAIL above_row_pix: got %b expected 0", bus.pix_on);
        end
        bus.DrawY = 10'd32; tick();
        n_checks++;
        if (bus.pix_on !== 1'b0) begin
            n_fail++; $display("FAIL below_row_pix: got %b expected 0", bus.pix_on);
        end
        bus.DrawX = 10'd91; bus.DrawY = 10'd31; #1;
        n_checks++;
        if (bus.rom_address !== 12'h7FF) begin
            n_fail++; $display("FAIL lsd_corner_addr: got %h expected 7ff", bus.rom_address);
        end
        bus.DrawX = 10'd16; bus.DrawY = 10'd16; bus.rom_q = 4'hF; tick();
        n_checks++;
        if (bus.pix_on !== !LZB || bus.pix_index !== (LZB ? 4'h0 : 4'hF)) begin
            n_fail++; $display("FAIL msd_zero_pix: got %b/%h expected %b/%h",
                               bus.pix_on, bus.pix_index, !LZB, LZB ? 4'h0 : 4'hF);
        end
        bus.blank = 1'b0; bus.rom_q = 4'h0;
    endtask

    task automatic check_row(input int score, input logic [3:0] lzb_mask, input string tag);
        logic [3:0] exp_mask;
        set_score(score);
        vblank_latch();
        exp_mask = LZB ? lzb_mask : 4'b1111;
        bus.blank = 1'b1; bus.rom_q = 4'h7; bus.DrawY = 10'd16;
        for (int k = 0; k < 4; k++) begin
            bus.DrawX = 10'(16 + 20 * k);
            tick();
            n_checks++;
            if (bus.pix_on !== exp_mask[3-k]) begin
                n_fail++; $display("FAIL lzb_%s_pos%0d: got %b expected %b", tag, k, bus.pix_on, exp_mask[3-k]);
            end
        end
        bus.blank = 1'b0; bus.rom_q = 4'h0;
    endtask

    task automatic test_lzb();
        check_row(42, 4'b0011, "0042");
        bus.DrawX = 10'd56; bus.DrawY = 10'd16; #1;
        n_checks++;
        if (bus.rom_address !== 12'h400) begin
            n_fail++; $display("FAIL lzb_0042_addr_pos2: got %h expected 400", bus.rom_address);
        end
        check_row(0, 4'b0001, "0000");
        check_row(402, 4'b0111, "0402");
    endtask

    task automatic test_reset_midframe();
        set_score(3);
        vblank_latch();
        bus.DrawX = 10'd76; bus.DrawY = 10'd16; bus.blank = 1'b1; bus.rom_q = 4'h7;
        tick();
        n_checks++;
        if (bus.pix_on !== 1'b1 || bus.rom_address !== 12'h300) begin
            n_fail++; $display("FAIL rstmid_before: got %b/%h expected 1/300", bus.pix_on, bus.rom_address);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.pix_on !== 1'b0 || bus.pix_index !== 4'h0 || bus.score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL rstmid_dark: got %b/%h/%h expected 0/0/0000",
                               bus.pix_on, bus.pix_index, bus.score_bcd);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.rom_address !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_display_zero: got %h expected 000", bus.rom_address);
        end
        bus.blank = 1'b0; bus.rom_q = 4'h0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.score_inc = 1'b0;
        bus.score_clr = 1'b0;
        bus.DrawX     = 10'd0;
        bus.DrawY     = 10'd0;
        bus.blank     = 1'b0;
        bus.rom_q     = 4'h0;
        test_reset();
        test_count();
        test_overflow();
        test_latch_same_cycle();
        test_midframe();
        test_pixel();
        test_lzb();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
